hack_fetch_unit: RTL and testbench
==================================

# hack_fetch_unit

Instruction fetch stage that drives the Hack program counter and the instruction ROM. It reads the current PC value, issues a req/ack read to instruction memory, and holds the returned 16-bit instruction behind a valid/ready handshake for the CPU. It also converts jump requests from the CPU into PC load commands. The PC advances only when an instruction has actually been fetched, and in-flight reads are drained safely on redirects.

## Interface
- ADDR_W, 15, width of PC / ROM address
- INSTR_W, 16, instruction width

- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- fetch_enable  in  1  level; 1 = keep fetching, 0 = halt after current instruction
- pc_in  in  ADDR_W  current PC register output
- pc_inc  out  ADDR_W→1  PC increment command (combinational)
- pc_load  out  1  PC load command (combinational)
- pc_next  out  ADDR_W  PC load value (combinational, = jump_target)
- imem_req  out  1  ROM read request
- imem_addr  out  ADDR_W  ROM read address (registered)
- imem_ack  in  1  ROM read done; imem_data valid this cycle
- imem_data  in  INSTR_W  ROM read data
- instr_valid  out  1  instruction available
- instr  out  INSTR_W  held instruction (registered)
- instr_addr  out  ADDR_W  address instr was fetched from (registered)
- instr_ready  in  1  CPU accepts instr
- jump  in  1  one-cycle redirect pulse
- jump_target  in  ADDR_W  redirect address

## Operation
- FSM states: IDLE, REQ, HOLD, REDIR, DRAIN.
- IDLE: no request, instr_valid=0. Next state:
  - jump → REDIR
  - else fetch_enable → REQ
- REQ: imem_req=1, imem_addr stable. Next state:
  - ack & !jump: capture imem_data→instr and imem_addr→instr_addr; pc_inc=1; → HOLD
  - ack & jump: discard data; pc_inc=0 → REDIR
  - !ack & jump → DRAIN
  - !ack & !jump: stay
- HOLD: instr_valid=1. Next state:
  - jump → REDIR; instr dropped, instr_valid=0 next cycle
  - else instr_ready: fetch_enable → REQ, else → IDLE
  - else stay
- REDIR: one settle cycle so the loaded PC is visible. Next state:
  - jump → REDIR
  - fetch_enable → REQ
  - else → IDLE
- DRAIN: imem_req=1, same imem_addr; the bus request is never abandoned. Next state:
  - ack & !jump: discard data → REQ if fetch_enable, else IDLE
  - ack & jump → REDIR
  - !ack: stay; a jump here reloads the PC, last target wins
- imem_addr is loaded from pc_in on every transition into REQ and held until ack.
- pc_load = jump and pc_next = jump_target in every state. jump has priority over pc_inc: pc_inc = (state==REQ) & imem_ack & !jump.
- fetch_enable falling during REQ does not cancel the read. The instruction is still delivered, then the FSM goes to IDLE.
- Address arithmetic is entirely in the PC (15-bit wrap 0x7FFF→0x0000); this block does no arithmetic.

## Timing
- Reset (async assert, sync release) puts the FSM in IDLE and sets instr=0, instr_addr=0, imem_addr=0. imem_req, instr_valid, pc_inc and pc_load read 0 (pc_load follows jump).
- Start latency: fetch_enable sampled high in IDLE at edge N → imem_req=1 in cycle N+1.
- Zero-wait ROM (ack in the first REQ cycle): instr_valid in cycle N+2, with pc_in already incremented.
- Throughput with ack immediate and ready=1: one instruction per 2 cycles (REQ, HOLD).
- Each wait state on imem_ack adds one cycle. imem_req and imem_addr stay constant until ack.
- Jump redirect: first request to jump_target is issued 2 cycles after the jump cycle (REDIR, then REQ).
- instr and instr_addr are stable while instr_valid=1 and instr_ready=0.
- reset_n asserted mid-REQ: the request drops immediately; the ROM must tolerate an aborted read.

## Test plan
- Reset, pc_in=0, enable=1, ROM zero-wait returning 0x1234 at 0 → req at cycle 1 with addr 0. pc_inc pulses in cycle 1. instr_valid=1, instr=0x1234, instr_addr=0 in cycle 2.
- ROM ack delayed 3 cycles, ready tied 1 → imem_req high 4 cycles with imem_addr constant. Exactly one pc_inc pulse per instruction.
- ready held 0 for 5 cycles in HOLD → instr and instr_addr unchanged. No new imem_req and no pc_inc.
- jump to 0x0100 while REQ waits on ack → pc_load=1 with pc_next=0x0100. imem_req stays until ack and that data is discarded. Next request has addr 0x0100 with no instr_valid in between.
- jump and ack in the same REQ cycle → pc_inc=0, pc_load=1, no instr_valid. Next addr = jump_target.
- enable dropped mid-REQ → one instruction is delivered, then IDLE with imem_req=0. Re-enable → fetch resumes at pc_in.

Source files
------------

// File: rtl/hack_fetch_unit.sv
// Hack instruction fetch stage: sequences ROM reads from the PC and holds each
// instruction behind a valid/ready handshake, turning CPU jumps into PC loads.
module hack_fetch_unit #(
   parameter int unsigned ADDR_W  = 15,
   parameter int unsigned INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               fetch_enable,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic               pc_inc,
   output logic               pc_load,
   output logic [ADDR_W-1:0]  pc_next,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  instr_addr,
   input  logic               instr_ready,
   input  logic               jump,
   input  logic [ADDR_W-1:0]  jump_target
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_HOLD,
      S_REDIR,
      S_DRAIN
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  imem_addr_q, imem_addr_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic [ADDR_W-1:0]  instr_addr_q, instr_addr_d;
   logic               start_req;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         imem_addr_q  <= '0;
         instr_q      <= '0;
         instr_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         imem_addr_q  <= imem_addr_d;
         instr_q      <= instr_d;
         instr_addr_q <= instr_addr_d;
      end
   end

   // Next-state and command decode; a jump always wins over a PC increment
   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      instr_addr_d = instr_addr_q;
      start_req    = 1'b0;
      pc_inc       = 1'b0;
      imem_req     = 1'b0;
      instr_valid  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (jump) begin
               state_d = S_REDIR;
            end else if (fetch_enable) begin
               start_req = 1'b1;
            end
         end
         S_REQ: begin
            imem_req = 1'b1;
            if (imem_ack && !jump) begin
               instr_d      = imem_data;
               instr_addr_d = imem_addr_q;
               pc_inc       = 1'b1;
               state_d      = S_HOLD;
            end else if (jump) begin
               state_d = imem_ack ? S_REDIR : S_DRAIN;
            end
         end
         S_HOLD: begin
            instr_valid = 1'b1;
            if (jump) begin
               state_d = S_REDIR;
            end else if (instr_ready) begin
               if (fetch_enable) begin
                  start_req = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_REDIR: begin
            if (jump) begin
               state_d = S_REDIR;
            end else if (fetch_enable) begin
               start_req = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_DRAIN: begin
            // The outstanding read must complete; its data is thrown away
            imem_req = 1'b1;
            if (imem_ack) begin
               if (jump) begin
                  state_d = S_REDIR;
               end else if (fetch_enable) begin
                  start_req = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (start_req) begin
         state_d = S_REQ;
      end
   end

   // The ROM address is captured from the PC only when a new read begins
   always_comb begin
      imem_addr_d = imem_addr_q;
      if (start_req) begin
         imem_addr_d = pc_in;
      end
   end

   assign pc_load    = jump;
   assign pc_next    = jump_target;
   assign imem_addr  = imem_addr_q;
   assign instr      = instr_q;
   assign instr_addr = instr_addr_q;

endmodule

// File: tb/tb_hack_fetch_unit.sv
// Directed bench for hack_fetch_unit with a PC/ROM environment model and a
// scoreboard that checks every accepted instruction against pushed expectations.
module tb_hack_fetch_unit;

   localparam int unsigned ADDR_W  = 15;
   localparam int unsigned INSTR_W = 16;

   logic               clk;
   logic               reset_n;
   logic               fetch_enable;
   logic [ADDR_W-1:0]  pc_in;
   logic               pc_inc;
   logic               pc_load;
   logic [ADDR_W-1:0]  pc_next;
   logic               imem_req;
   logic [ADDR_W-1:0]  imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_data;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_addr;
   logic               instr_ready;
   logic               jump;
   logic [ADDR_W-1:0]  jump_target;

   int total = 0;
   int bad   = 0;
   int n_inc = 0;
   int n_pop = 0;
   int ack_lat;
   int req_cnt;

   logic [INSTR_W+ADDR_W-1:0] exp_q[$];

   hack_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_enable(fetch_enable),
      .pc_in       (pc_in),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .pc_next     (pc_next),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_addr  (instr_addr),
      .instr_ready (instr_ready),
      .jump        (jump),
      .jump_target (jump_target)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // PC register: load has priority over increment, 15-bit wrap
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)     pc_in <= '0;
      else if (pc_load) pc_in <= pc_next;
      else if (pc_inc)  pc_in <= pc_in + 15'd1;
   end

   // ROM: acks after ack_lat wait cycles; content is 0x1234 xor address
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                  req_cnt <= 0;
      else if (imem_req && !imem_ack) req_cnt <= req_cnt + 1;
      else                           req_cnt <= 0;
   end
   assign imem_ack  = imem_req && (req_cnt == ack_lat);
   assign imem_data = 16'h1234 ^ {1'b0, imem_addr};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   // Scoreboard monitor: every handshake must match the oldest expectation
   always @(negedge clk) begin
      if (reset_n && pc_inc) n_inc++;
      if (reset_n && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: instr 0x%0h addr 0x%0h with nothing expected", instr, instr_addr);
         end else begin
            logic [INSTR_W+ADDR_W-1:0] e;
            e = exp_q.pop_front();
            n_pop++;
            chk("sb_instr", 32'(instr), 32'(e[INSTR_W+ADDR_W-1:ADDR_W]));
            chk("sb_addr", 32'(instr_addr), 32'(e[ADDR_W-1:0]));
         end
      end
   end

   initial begin
      reset_n = 1'b0; fetch_enable = 1'b0; instr_ready = 1'b1;
      jump = 1'b0; jump_target = '0; ack_lat = 0;
      mid();
      chk("rst_req",    32'(imem_req),    32'd0);
      chk("rst_valid",  32'(instr_valid), 32'd0);
      chk("rst_instr",  32'(instr),       32'd0);
      chk("rst_iaddr",  32'(instr_addr),  32'd0);
      chk("rst_maddr",  32'(imem_addr),   32'd0);
      chk("rst_pc_inc", 32'(pc_inc),      32'd0);
      chk("rst_pc_load",32'(pc_load),     32'd0);
      adv(); reset_n = 1'b1;

      // zero-wait fetch from 0
      adv(); fetch_enable = 1'b1;
      mid(); chk("idle_req", 32'(imem_req), 32'd0);
      exp_q.push_back({16'h1234, 15'h0000});
      adv(); mid();
      chk("t1_req", 32'(imem_req), 32'd1);
      chk("t1_addr", 32'(imem_addr), 32'd0);
      chk("t1_pc_inc", 32'(pc_inc), 32'd1);
      adv(); ack_lat = 3;
      mid();
      chk("t1_valid", 32'(instr_valid), 32'd1);
      chk("t1_instr", 32'(instr), 32'h1234);
      chk("t1_iaddr", 32'(instr_addr), 32'd0);
      chk("t1_pc", 32'(pc_in), 32'd1);

      // three ROM wait states: request held four cycles
      exp_q.push_back({16'h1235, 15'h0001});
      for (int i = 0; i < 4; i++) begin
         adv(); mid();
         chk("t2_req", 32'(imem_req), 32'd1);
         chk("t2_addr", 32'(imem_addr), 32'd1);
         chk("t2_pc_inc", 32'(pc_inc), (i == 3) ? 32'd1 : 32'd0);
      end

      // ready held low: instruction stays put, no new request
      adv(); instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         mid();
         chk("t3_valid", 32'(instr_valid), 32'd1);
         chk("t3_instr", 32'(instr), 32'h1235);
         chk("t3_iaddr", 32'(instr_addr), 32'd1);
         chk("t3_req", 32'(imem_req), 32'd0);
         chk("t3_pc_inc", 32'(pc_inc), 32'd0);
         adv();
      end
      instr_ready = 1'b1; ack_lat = 2;
      mid();

      // jump while REQ waits on ack: read drained, then fetch at target
      adv(); jump = 1'b1; jump_target = 15'h0100;
      mid();
      chk("t4_req", 32'(imem_req), 32'd1);
      chk("t4_addr", 32'(imem_addr), 32'd2);
      chk("t4_pc_load", 32'(pc_load), 32'd1);
      chk("t4_pc_next", 32'(pc_next), 32'h0100);
      chk("t4_pc_inc", 32'(pc_inc), 32'd0);
      adv(); jump = 1'b0;
      mid();
      chk("t4_drain_req", 32'(imem_req), 32'd1);
      chk("t4_drain_addr", 32'(imem_addr), 32'd2);
      chk("t4_drain_valid", 32'(instr_valid), 32'd0);
      adv(); mid();
      chk("t4_drain_ack", 32'(imem_ack), 32'd1);
      chk("t4_drain_inc", 32'(pc_inc), 32'd0);

      // jump coinciding with ack: data dropped, no increment
      adv(); ack_lat = 0; jump = 1'b1; jump_target = 15'h0200;
      mid();
      chk("t5_req", 32'(imem_req), 32'd1);
      chk("t5_addr", 32'(imem_addr), 32'h0100);
      chk("t5_ack", 32'(imem_ack), 32'd1);
      chk("t5_pc_inc", 32'(pc_inc), 32'd0);
      chk("t5_pc_load", 32'(pc_load), 32'd1);
      adv(); jump = 1'b0; ack_lat = 1;
      mid();
      chk("t5_redir_req", 32'(imem_req), 32'd0);
      chk("t5_redir_valid", 32'(instr_valid), 32'd0);
      chk("t5_pc", 32'(pc_in), 32'h0200);

      // enable dropped mid-REQ: instruction still delivered, then idle
      adv(); fetch_enable = 1'b0;
      exp_q.push_back({16'h1034, 15'h0200});
      mid();
      chk("t6_req", 32'(imem_req), 32'd1);
      chk("t6_addr", 32'(imem_addr), 32'h0200);
      chk("t6_pc_inc0", 32'(pc_inc), 32'd0);
      adv(); mid();
      chk("t6_pc_inc1", 32'(pc_inc), 32'd1);
      adv(); mid();
      chk("t6_valid", 32'(instr_valid), 32'd1);
      adv(); mid();
      chk("t6_idle_req", 32'(imem_req), 32'd0);
      chk("t6_idle_valid", 32'(instr_valid), 32'd0);
      adv(); mid();
      chk("t6_idle_req2", 32'(imem_req), 32'd0);

      // re-enable resumes at the incremented PC
      adv(); fetch_enable = 1'b1;
      exp_q.push_back({16'h1035, 15'h0201});
      mid();
      adv(); fetch_enable = 1'b0;
      mid();
      chk("t7_req", 32'(imem_req), 32'd1);
      chk("t7_addr", 32'(imem_addr), 32'h0201);
      adv(); mid();
      chk("t7_pc_inc", 32'(pc_inc), 32'd1);
      adv(); mid();
      chk("t7_valid", 32'(instr_valid), 32'd1);
      adv(); adv(); mid();
      chk("t7_idle_req", 32'(imem_req), 32'd0);
      chk("n_inc", 32'(n_inc), 32'd4);
      chk("n_pop", 32'(n_pop), 32'd4);
      chk("q_empty", 32'(exp_q.size()), 32'd0);

      // reset during a pending read drops the request at once
      adv(); fetch_enable = 1'b1; ack_lat = 5;
      adv(); mid();
      chk("t8_req", 32'(imem_req), 32'd1);
      reset_n = 1'b0;
      #1;
      chk("t8_req_abort", 32'(imem_req), 32'd0);
      chk("t8_maddr", 32'(imem_addr), 32'd0);
      fetch_enable = 1'b0;
      adv(); reset_n = 1'b1;
      adv(); mid();
      chk("t8_idle", 32'(imem_req), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
